// File: rtl/axil_buffet_fill_engine.sv
// axil_buffet_fill_engine: strided AXI4-Lite read-fill engine feeding the buffet push port.
module axil_buffet_fill_engine #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int LEN_WIDTH       = 8,
  parameter int MAX_OUTSTANDING = 4,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                  AXI_ACLK,
  input  logic                  AXI_ARESETN,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] stride,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [2:0]            M_AXI_ARPROT,
  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]            M_AXI_RRESP,
  input  logic                  M_AXI_RVALID,
  output logic                  M_AXI_RREADY,
  output logic [DATA_WIDTH-1:0] push_data,
  output logic                  push_data_valid,
  input  logic                  push_data_ready
);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;
  state_t state;
  logic [ADDR_WIDTH-1:0] addr, step;
  logic [LEN_WIDTH-1:0] total, issued, pushed;
  logic [OW-1:0] outstanding;
  logic [CW-1:0] count;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [31:0] reserved;
  logic ar_fire, r_fire, p_fire;
  // Every AR in flight or beat parked in the FIFO holds a slot, so R is always acceptable.
  assign reserved = 32'(outstanding) + 32'(count);
  assign M_AXI_ARVALID = state == RUN && issued < total && 32'(outstanding) < 32'(MAX_OUTSTANDING)
                         && reserved < 32'(FIFO_DEPTH);
  assign M_AXI_ARADDR = addr;
  assign M_AXI_ARPROT = 3'b000;
  assign M_AXI_RREADY = busy;
  assign push_data_valid = count != '0;
  assign push_data = push_data_valid ? mem[rd_ptr] : '0;
  assign ar_fire = M_AXI_ARVALID && M_AXI_ARREADY;
  assign r_fire = M_AXI_RVALID && busy && outstanding != '0;
  assign p_fire = push_data_valid && push_data_ready;
  always_ff @(posedge AXI_ACLK)
    if (r_fire) mem[wr_ptr] <= M_AXI_RDATA;
  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN)
    if (!AXI_ARESETN) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
      addr <= '0;
      step <= '0;
      total <= '0;
      issued <= '0;
      pushed <= '0;
      outstanding <= '0;
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      done <= state == FIN;
      if (ar_fire) begin
        addr <= addr + step;
        issued <= issued + 1'b1;
      end
      if (p_fire) pushed <= pushed + 1'b1;
      if (ar_fire != r_fire) outstanding <= ar_fire ? outstanding + 1'b1 : outstanding - 1'b1;
      if (r_fire != p_fire) count <= r_fire ? count + 1'b1 : count - 1'b1;
      if (r_fire) wr_ptr <= wr_ptr == PW'(FIFO_DEPTH - 1) ? '0 : wr_ptr + 1'b1;
      if (p_fire) rd_ptr <= rd_ptr == PW'(FIFO_DEPTH - 1) ? '0 : rd_ptr + 1'b1;
      if (r_fire && M_AXI_RRESP != 2'b00) error <= 1'b1;
      case (state)
        IDLE: if (start) begin
          addr <= base_addr;
          step <= stride;
          total <= len;
          issued <= '0;
          pushed <= '0;
          error <= 1'b0;
          busy <= len != '0;
          state <= len == '0 ? FIN : RUN;
        end
        RUN: if (ar_fire && issued + 1'b1 == total) state <= DRAIN;
        DRAIN: if (p_fire && pushed + 1'b1 == total) begin
          state <= FIN;
          busy <= 1'b0;
        end
        FIN: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_axil_buffet_fill_engine.sv
// tb_axil_buffet_fill_engine: directed job table plus reset and zero-length sequences against a
// reactive AXI-Lite slave that checks addresses and pushed data.
module tb_axil_buffet_fill_engine;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [31:0] base_addr = '0, stride = '0;
  logic [7:0] len = '0;
  logic busy, done, error;
  logic [31:0] araddr;
  logic [2:0] arprot;
  logic arvalid, arready = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0] rresp = '0;
  logic rvalid = 1'b0, rready;
  logic [31:0] push_data;
  logic push_valid, push_ready = 1'b0;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  axil_buffet_fill_engine dut (
    .AXI_ACLK(clk), .AXI_ARESETN(rst_n), .start(start), .base_addr(base_addr), .stride(stride),
    .len(len), .busy(busy), .done(done), .error(error), .M_AXI_ARADDR(araddr),
    .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
    .push_data(push_data), .push_data_valid(push_valid), .push_data_ready(push_ready)
  );

  typedef struct {
    logic [31:0] base, stride;
    int len, bad, r_hold, stall;
    bit throttle, chk_out, chk_res;
  } vec_t;
  vec_t vecs[7];

  logic [31:0] q[$];
  logic [31:0] exp_base, exp_stride, prev_addr;
  logic [31:0] ar_log[16];
  int ar_cnt, r_cnt, push_cnt, done_cnt, max_out, max_res, r_idx, exp_bad = -1, r_hold, tick;
  bit throttle, bad_pending, bad_seen, prev_stall;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], ~a[31:16]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Slave + monitor: decide this cycle's drive at the falling edge; handshakes land on the next rise.
  initial forever begin
    @(negedge clk);
    tick++;
    if (!rst_n) begin
      q.delete();
      rvalid = 1'b0;
      arready = 1'b0;
      bad_pending = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (bad_pending) bad_seen = 1'b1;
      bad_pending = 1'b0;
      if (busy) check("error_track", error, bad_seen);
      if (prev_stall) begin
        check("ar_hold_valid", arvalid, 1);
        check("ar_hold_addr", araddr, prev_addr);
      end
      if (done) done_cnt++;
      if (r_hold > 0) begin
        r_hold--;
        rvalid = 1'b0;
      end else rvalid = q.size() != 0;
      if (rvalid) begin
        rdata = mem_data(q[0]);
        rresp = r_idx == exp_bad ? 2'b10 : 2'b00;
        if (rready) begin
          void'(q.pop_front());
          bad_pending = rresp != 2'b00;
          r_idx++;
          r_cnt++;
        end
      end
      arready = !throttle || (tick % 3 != 0);
      prev_stall = arvalid && !arready;
      prev_addr = araddr;
      if (arvalid && arready) begin
        check("ar_addr", araddr, exp_base + ar_cnt * exp_stride);
        if (ar_cnt < 16) ar_log[ar_cnt] = araddr;
        q.push_back(araddr);
        ar_cnt++;
      end
      if (push_valid && push_ready) begin
        check("push_data", push_data, mem_data(exp_base + push_cnt * exp_stride));
        push_cnt++;
      end
      if (ar_cnt - r_cnt > max_out) max_out = ar_cnt - r_cnt;
      if (ar_cnt - push_cnt > max_res) max_res = ar_cnt - push_cnt;
    end
  end

  task automatic clear_tracking(input logic [31:0] b, input logic [31:0] s, input int bad, input int hold,
                                input bit thr);
    exp_base = b;
    exp_stride = s;
    exp_bad = bad;
    r_hold = hold;
    throttle = thr;
    ar_cnt = 0;
    r_cnt = 0;
    push_cnt = 0;
    done_cnt = 0;
    max_out = 0;
    max_res = 0;
    r_idx = 0;
    bad_seen = 1'b0;
  endtask

  task automatic run_job(input vec_t v);
    clear_tracking(v.base, v.stride, v.bad, v.r_hold, v.throttle);
    start = 1'b1;
    base_addr = v.base;
    stride = v.stride;
    len = 8'(v.len);
    push_ready = v.stall == 0;
    @(posedge clk); #1;
    start = 1'b0;
    check("error_cleared", error, 0);
    check("busy_after_start", busy, 1);
    for (int c = 0; c < 600 && done_cnt == 0; c++) begin
      if (c >= v.stall) push_ready = 1'b1;
      if (v.stall > 0 && c == 3) begin
        start = 1'b1;
        base_addr = 32'hDEAD_0000;
        len = 8'd1;
      end else start = 1'b0;
      @(posedge clk); #1;
    end
    start = 1'b0;
    if (done_cnt == 0) begin
      errors++;
      $display("FAIL job_timeout: got no done, expected done within 600 cycles");
    end
    repeat (2) @(posedge clk);
    #1;
    check("ar_count", ar_cnt, v.len);
    check("push_count", push_cnt, v.len);
    check("done_pulses", done_cnt, 1);
    check("busy_end", busy, 0);
    check("error_end", error, (v.bad >= 0 && v.bad < v.len) ? 1 : 0);
    check("max_outstanding_le", max_out <= 4, 1);
    check("max_reserved_le", max_res <= 8, 1);
    if (v.chk_out) check("max_outstanding_eq", max_out, 4);
    if (v.chk_res) check("max_reserved_eq", max_res, 8);
  endtask

  initial begin
    vecs[0] = '{32'h0000_0100, 32'd4, 4, -1, 0, 0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'h0000_2000, 32'd8, 8, -1, 10, 0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{32'h0000_4000, 32'd4, 16, -1, 0, 20, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{32'hFFFF_FFF8, 32'd4, 4, -1, 0, 0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{32'h0000_0300, 32'd4, 4, 2, 0, 0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{32'h0000_0500, 32'h10, 5, -1, 0, 0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{32'h0000_1000, 32'hFFFF_FFFC, 6, 0, 3, 4, 1'b1, 1'b0, 1'b0};
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_arvalid", arvalid, 0);
    check("rst_araddr", araddr, 0);
    check("rst_arprot", arprot, 0);
    check("rst_rready", rready, 0);
    check("rst_push_valid", push_valid, 0);
    check("rst_push_data", push_data, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    foreach (vecs[i]) begin
      run_job(vecs[i]);
      if (i == 0) begin
        check("t1_addr0", ar_log[0], 32'h100);
        check("t1_addr3", ar_log[3], 32'h10C);
      end
      if (i == 3) begin
        check("t4_addr1", ar_log[1], 32'hFFFF_FFFC);
        check("t4_addr2", ar_log[2], 32'h0);
        check("t4_addr3", ar_log[3], 32'h4);
      end
    end
    // Zero-length job: error from the previous job is cleared, done two edges after start.
    clear_tracking(32'h700, 32'd4, -1, 0, 1'b0);
    start = 1'b1;
    base_addr = 32'h700;
    len = 8'd0;
    @(posedge clk); #1;
    start = 1'b0;
    check("len0_busy", busy, 0);
    check("len0_done_early", done, 0);
    check("len0_error", error, 0);
    @(posedge clk); #1;
    check("len0_done", done, 1);
    @(posedge clk); #1;
    check("len0_done_end", done, 0);
    check("len0_no_ar", ar_cnt, 0);
    check("len0_pulses", done_cnt, 1);
    // Reset in the middle of a job with three reads outstanding.
    clear_tracking(32'h8000, 32'd4, -1, 40, 1'b0);
    start = 1'b1;
    base_addr = 32'h8000;
    stride = 32'd4;
    len = 8'd16;
    push_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 20 && ar_cnt < 3; c++) @(posedge clk);
    check("mid_busy", busy, 1);
    #3 rst_n = 1'b0;
    #1;
    check("arst_arvalid", arvalid, 0);
    check("arst_araddr", araddr, 0);
    check("arst_rready", rready, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_error", error, 0);
    check("arst_push_valid", push_valid, 0);
    check("arst_push_data", push_data, 0);
    repeat (3) @(posedge clk);
    #1;
    check("arst_no_done", done_cnt, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_job('{32'h0000_9000, 32'd4, 6, -1, 0, 0, 1'b0, 1'b0, 1'b0});
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
